// File: rtl/pll_lock_sequencer_if.sv
// Bundle between the PLL lock sequencer and the PLL / serializer side.
// master: sequencer (lock/request in, resets/status out); slave: the far side.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       clkdiv_resetn;
    logic       ser_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;

    modport master (
        input  pll_lock, relock_req,
        output pll_reset, clkdiv_resetn, ser_reset, ready, fault, retry_cnt
    );

    modport slave (
        output pll_lock, relock_req,
        input  pll_reset, clkdiv_resetn, ser_reset, ready, fault, retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences rPLL reset, lock qualification, then CLKDIV and OSER10 reset release.
// Ports: clkin, reset_n (sync, active low), pll_if (pll_lock_sequencer_if.master).
module pll_lock_sequencer #(
    parameter int RESET_PULSE_CYC  = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int DIV_SETTLE_CYC   = 8,
    parameter int MAX_RETRIES      = 7
) (
    input  logic                  clkin,
    input  logic                  reset_n,
    pll_lock_sequencer_if.master  pll_if
);

    localparam int PW = $clog2(RESET_PULSE_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int DW = $clog2(DIV_SETTLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RESET_PULSE_CYC - 1);
    localparam logic [DW-1:0] SETTLE_LAST = DW'(DIV_SETTLE_CYC - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_PULSE, WAIT_LOCK, LOCK_STABLE, DIV_REL, SER_REL, RUN, FAULT
    } state_e;

    // {pll_reset, clkdiv_resetn, ser_reset, ready, fault}
    localparam logic [4:0] OUTS_RST = 5'b10100;

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [DW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    retry_q, retry_d;
    logic [4:0]    outs_q, outs_d;

    logic lock_s;
    logic tmo_hit;
    logic stab_done;

    function automatic logic [4:0] decode(state_e s);
        logic [4:0] o;
        o = OUTS_RST;
        case (s)
            RST_PULSE:   o = 5'b10100;
            WAIT_LOCK:   o = 5'b00100;
            LOCK_STABLE: o = 5'b00100;
            DIV_REL:     o = 5'b01100;
            SER_REL:     o = 5'b01000;
            RUN:         o = 5'b01010;
            FAULT:       o = 5'b10101;
            default:     o = OUTS_RST;
        endcase
        return o;
    endfunction

    assign lock_s  = sync_q[1];
    assign tmo_hit = int'(tmo_q) >= LOCK_TIMEOUT_CYC - 1;
    // The WAIT_LOCK cycle that first sees lock_s is the first stable cycle,
    // so LOCK_STABLE itself only needs LOCK_STABLE_CYC-1 more high cycles.
    assign stab_done = int'(stab_q) + 2 >= LOCK_STABLE_CYC;

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[0], pll_if.pll_lock};
        pulse_d  = pulse_q;
        stab_d   = stab_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;

        if (state_q == WAIT_LOCK || state_q == LOCK_STABLE) begin
            if (int'(tmo_q) < LOCK_TIMEOUT_CYC) tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            RST_PULSE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    pulse_d = '0;
                    tmo_d   = '0;
                end else begin
                    pulse_d = pulse_q + PW'(1);
                end
            end
            WAIT_LOCK, LOCK_STABLE: begin
                if (state_q == LOCK_STABLE && lock_s && stab_done) begin
                    state_d  = DIV_REL;
                    settle_d = '0;
                end else if (tmo_hit) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RST_PULSE;
                        retry_d = retry_q + 4'd1;
                    end
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (state_q == WAIT_LOCK) begin
                    stab_d   = '0;
                    settle_d = '0;
                    state_d  = (LOCK_STABLE_CYC == 1) ? DIV_REL : LOCK_STABLE;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            DIV_REL: begin
                if (!lock_s) begin
                    state_d = RST_PULSE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = SER_REL;
                end else begin
                    settle_d = settle_q + DW'(1);
                end
            end
            SER_REL: begin
                if (!lock_s) begin
                    state_d = RST_PULSE;
                end else begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) state_d = RST_PULSE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = RST_PULSE;
        endcase

        // Software restart overrides every other transition.
        if (pll_if.relock_req) begin
            state_d  = RST_PULSE;
            pulse_d  = '0;
            stab_d   = '0;
            settle_d = '0;
            tmo_d    = '0;
            retry_d  = '0;
        end

        outs_d = decode(state_d);
    end

    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state_q  <= RST_PULSE;
            sync_q   <= '0;
            pulse_q  <= '0;
            stab_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            outs_q   <= OUTS_RST;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            pulse_q  <= pulse_d;
            stab_q   <= stab_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            outs_q   <= outs_d;
        end
    end

    assign pll_if.pll_reset     = outs_q[4];
    assign pll_if.clkdiv_resetn = outs_q[3];
    assign pll_if.ser_reset     = outs_q[2];
    assign pll_if.ready         = outs_q[1];
    assign pll_if.fault         = outs_q[0];
    assign pll_if.retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pll_lock_sequencer;

    logic clkin = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;
    int   order_viol = 0;
    int   len;
    int   bad;
    logic prst_seen;

    always #5 clkin = ~clkin;

    pll_lock_sequencer_if sif ();

    pll_lock_sequencer #(
        .RESET_PULSE_CYC (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(64),
        .DIV_SETTLE_CYC  (4),
        .MAX_RETRIES     (2)
    ) dut (
        .clkin  (clkin),
        .reset_n(reset_n),
        .pll_if (sif)
    );

    always @(negedge clkin) begin
        if (reset_n) begin
            if (!sif.ser_reset && !sif.clkdiv_resetn) order_viol++;
            if (sif.clkdiv_resetn && sif.pll_reset) order_viol++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clkin);
            prst_seen |= sif.pll_reset;
        end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(sif.pll_reset);
            1:       return int'(sif.clkdiv_resetn);
            2:       return int'(sif.ready);
            default: return int'(sif.fault);
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel,
                            input int val, input int budget);
        int n;
        n = 0;
        while (sig(sel) != val && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, sig(sel), val);
    endtask

    // Counts consecutive sampled cycles, including the current one.
    task automatic run_len(input int sel, input int val, output int l);
        l = 0;
        while (sig(sel) == val && l < 1000) begin
            l++;
            tick(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_prst"}, sig(0), 1);
        check({tag, "_cdiv"}, sig(1), 0);
        check({tag, "_ser"}, int'(sif.ser_reset), 1);
        check({tag, "_rdy"}, sig(2), 0);
        check({tag, "_flt"}, sig(3), 0);
        check({tag, "_retry"}, int'(sif.retry_cnt), 0);
    endtask

    task automatic reset_dut();
        reset_n        = 1'b0;
        sif.pll_lock   = 1'b0;
        sif.relock_req = 1'b0;
        tick(3);
    endtask

    initial begin
        prst_seen = 1'b0;
        reset_dut();
        check_reset_vals("rst");

        // Nominal lock
        reset_n = 1'b1;
        run_len(0, 1, len);
        check("nom_pulse_len", len, 4);
        tick(10);
        sif.pll_lock = 1'b1;
        tick(9);
        check("nom_cdiv_early", sig(1), 0);
        tick(1);
        check("nom_cdiv_rise", sig(1), 1);
        check("nom_ser_hold", int'(sif.ser_reset), 1);
        tick(3);
        check("nom_ser_early", int'(sif.ser_reset), 1);
        tick(1);
        check("nom_ser_fall", int'(sif.ser_reset), 0);
        check("nom_rdy_early", sig(2), 0);
        tick(1);
        check("nom_rdy", sig(2), 1);
        check("nom_retry", int'(sif.retry_cnt), 0);

        // Lock loss in RUN
        sif.pll_lock = 1'b0;
        tick(1);
        sif.pll_lock = 1'b1;
        tick(1);
        check("loss_rdy_hold", sig(2), 1);
        tick(1);
        check("loss_rdy", sig(2), 0);
        check("loss_prst", sig(0), 1);
        check("loss_cdiv", sig(1), 0);
        check("loss_ser", int'(sif.ser_reset), 1);
        run_len(0, 1, len);
        check("loss_pulse_len", len, 4);
        wait_sig("loss_reseq_rdy", 2, 1, 100);
        check("loss_retry", int'(sif.retry_cnt), 0);

        // Lock glitch during qualification
        reset_dut();
        reset_n = 1'b1;
        wait_sig("gl_prst_fall", 0, 0, 20);
        tick(10);
        prst_seen = 1'b0;
        sif.pll_lock = 1'b1;
        tick(5);
        sif.pll_lock = 1'b0;
        tick(1);
        sif.pll_lock = 1'b1;
        tick(9);
        check("gl_cdiv_early", sig(1), 0);
        tick(1);
        check("gl_cdiv_rise", sig(1), 1);
        check("gl_no_prst", int'(prst_seen), 0);
        wait_sig("gl_rdy", 2, 1, 20);

        // Timeout and fault
        reset_dut();
        reset_n = 1'b1;
        run_len(0, 1, len);
        run_len(0, 0, len);
        check("to1_wait_len", len, 64);
        check("to1_retry", int'(sif.retry_cnt), 1);
        run_len(0, 1, len);
        check("to1_pulse_len", len, 4);
        run_len(0, 0, len);
        check("to2_wait_len", len, 64);
        check("to2_retry", int'(sif.retry_cnt), 2);
        run_len(0, 1, len);
        run_len(0, 0, len);
        check("to3_wait_len", len, 64);
        check("fault_set", sig(3), 1);
        check("fault_rdy", sig(2), 0);
        check("fault_prst", sig(0), 1);
        check("fault_cdiv", sig(1), 0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (sig(3) != 1) bad++;
        end
        check("fault_hold", bad, 0);

        // Recovery from FAULT
        sif.relock_req = 1'b1;
        tick(1);
        sif.relock_req = 1'b0;
        check("rec_fault", sig(3), 0);
        check("rec_retry", int'(sif.retry_cnt), 0);
        check("rec_prst", sig(0), 1);
        run_len(0, 1, len);
        check("rec_pulse_len", len, 4);
        sif.pll_lock = 1'b1;
        wait_sig("rec_rdy", 2, 1, 60);
        check("rec_retry_run", int'(sif.retry_cnt), 0);

        // relock_req on the timeout cycle
        reset_dut();
        reset_n = 1'b1;
        run_len(0, 1, len);
        tick(63);
        check("pri_pre_prst", sig(0), 0);
        sif.relock_req = 1'b1;
        tick(1);
        sif.relock_req = 1'b0;
        check("pri_prst", sig(0), 1);
        check("pri_retry", int'(sif.retry_cnt), 0);
        run_len(0, 1, len);
        check("pri_pulse_len", len, 4);

        // reset_n mid-DIV_REL
        sif.pll_lock = 1'b1;
        wait_sig("mid_cdiv", 1, 1, 40);
        tick(1);
        reset_n = 1'b0;
        tick(1);
        check_reset_vals("mid");
        reset_n = 1'b1;
        tick(2);

        check("order_invariant", order_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises the 200 MHz rPLL that feeds the HDMI OSER10/ELVDS serializer path.
- Pulses the PLL reset and qualifies LOCK for a stable interval.
- Then releases the CLKDIV reset and the serializer reset in order, and raises ready.
- On lock loss, lock timeout or a software request, it re-runs the sequence; after repeated timeouts it latches a fault.

Parameters:
- RESET_PULSE_CYC, 16: cycles pll_reset is held high per attempt (>=1).
- LOCK_STABLE_CYC, 1024: consecutive synced-lock-high cycles required before release (>=1).
- LOCK_TIMEOUT_CYC, 100000: cycles allowed from WAIT_LOCK entry to qualified lock.
- DIV_SETTLE_CYC, 8: cycles between clkdiv_resetn release and ser_reset release (>=1).
- MAX_RETRIES, 7: timeout retries before FAULT (0..15).

Ports:
- clkin  in  1  100 MHz reference clock, also the PLL input; the only clock.
- reset_n  in  1  synchronous active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clkin.
- relock_req  in  1  one-cycle request to restart the sequence.
- pll_reset  out  1  to PLL RESET, active high.
- clkdiv_resetn  out  1  to CLKDIV RESETN, active low.
- ser_reset  out  1  to OSER10 RESET, active high.
- ready  out  1  high in RUN only.
- fault  out  1  high in FAULT only.
- retry_cnt  out  4  timeouts taken in the current sequence.

Behaviour:
- Reset:
  - State = RST_PULSE; all counters 0; sync flops 0.
  - Outputs: pll_reset=1, clkdiv_resetn=0, ser_reset=1, ready=0, fault=0, retry_cnt=0.
- Lock synchronizer:
  - 2-flop synchronizer; lock_s = pll_lock delayed 2 clkin cycles.
  - All decisions use lock_s only.
- All outputs are registered and are a pure function of state.
- RST_PULSE:
  - pll_reset=1, clkdiv_resetn=0, ser_reset=1.
  - Stays exactly RESET_PULSE_CYC cycles, then goes to WAIT_LOCK.
  - Clears the timeout counter on exit.
- WAIT_LOCK:
  - pll_reset=0; the timeout counter increments every cycle.
  - lock_s=1 -> LOCK_STABLE with the stable counter = 0.
- LOCK_STABLE:
  - The stable counter increments while lock_s=1.
  - lock_s=0 -> back to WAIT_LOCK; the timeout counter is not cleared.
  - Stable counter reaches LOCK_STABLE_CYC -> DIV_REL.
- Timeout (WAIT_LOCK or LOCK_STABLE), when the timeout counter reaches LOCK_TIMEOUT_CYC:
  - retry_cnt == MAX_RETRIES -> FAULT.
  - Otherwise retry_cnt += 1 and go to RST_PULSE.
- DIV_REL:
  - clkdiv_resetn=1, ser_reset=1.
  - After DIV_SETTLE_CYC cycles -> SER_REL.
  - lock_s=0 -> RST_PULSE.
- SER_REL:
  - One cycle: ser_reset=0, then RUN.
  - lock_s=0 -> RST_PULSE.
- RUN:
  - ready=1, clkdiv_resetn=1, ser_reset=0; retry_cnt is held.
  - lock_s=0 for even one cycle -> RST_PULSE on the next edge.
  - Lock loss does not increment retry_cnt; retry_cnt is cleared on RUN entry.
- FAULT:
  - fault=1, pll_reset=1, clkdiv_resetn=0, ser_reset=1.
  - Exits only on relock_req or reset_n.
- relock_req:
  - Valid in any state; forces RST_PULSE and clears retry_cnt and all counters.
  - Takes priority over timeout and lock-loss transitions in the same cycle.
- Ordering invariant:
  - ser_reset never deasserts unless clkdiv_resetn is 1.
  - clkdiv_resetn never is 1 while pll_reset is 1.
- Reset mid-sequence:
  - reset_n=0 on any edge restores the reset values, irrespective of state.
- Counter widths: $clog2(param+1); no wrap, since counters saturate at their compare values.

Test Plan (RESET_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, DIV_SETTLE_CYC=4, MAX_RETRIES=2):
- Nominal lock:
  - Release reset, raise pll_lock 10 cycles after pll_reset falls.
  - Expect pll_reset high exactly 4 cycles.
  - Expect clkdiv_resetn rise 2+8 cycles after pll_lock rises.
  - Expect ser_reset fall 4 cycles later, then ready=1; retry_cnt=0.
- Lock glitch during qualification:
  - Lock high 5 cycles, low 1 cycle, then high.
  - Expect the stable count restarts and clkdiv_resetn releases 8 cycles after the second rise (+2 sync).
  - Expect no pll_reset pulse.
- Lock loss in RUN:
  - Drop pll_lock 1 cycle.
  - Expect ready=0, pll_reset=1, clkdiv_resetn=0, ser_reset=1 by 3 cycles after the drop.
  - Expect a full resequence and retry_cnt=0.
- Timeout and fault:
  - Keep pll_lock=0.
  - Expect pll_reset pulses with retry_cnt 1, then 2.
  - Expect the third timeout to enter FAULT: fault=1, ready=0, and it stays there for 500 cycles.
- Recovery from FAULT:
  - Pulse relock_req in FAULT, then provide lock.
  - Expect fault=0, retry_cnt=0, and a nominal sequence to ready=1.
- Priority:
  - Assert relock_req on the same cycle as the timeout expiry.
  - Expect RST_PULSE with retry_cnt=0, not an increment.
  - Also assert reset_n=0 mid-DIV_REL; expect all outputs at reset values next cycle.
